// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master arbiter and its round-robin picker.
package apb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [1:0] PORT1 = 2'd0;
  localparam logic [1:0] PORT2 = 2'd1;
  localparam logic [1:0] PORT3 = 2'd2;
  localparam logic [1:0] PORT4 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } xfer_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  int         w_sum;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = 0;
    w_pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_pos = IW'(w_sum);
      if (!o_any && i_req[w_pos]) begin
        o_any        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = ID_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB slave bridge among NUM_REQ requesters: round-robin grant,
// en/ready sequencing with timeout abort, and a minimum en-low recovery gap.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [2*NUM_REQ-1:0]      req_port,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic                      m_en,
  output logic                      m_wr,
  output logic [1:0]                m_sel_port,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_ready,
  output logic                      done_valid,
  output logic [ID_W-1:0]           done_id,
  output logic                      done_err,
  output logic                      busy
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > RECOVER_CYCLES) ? TIMEOUT_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [ID_W-1:0]  r_ptr, w_ptr;
  logic [ID_W-1:0]  r_id, w_id;
  xfer_t            r_xfer, w_xfer;
  logic             r_en, w_en;
  logic             r_dv, w_dv;
  logic [ID_W-1:0]  r_did, w_did;
  logic             r_derr, w_derr;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gidx;
  logic               w_any;
  xfer_t              w_req [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_req[gi] = {req_wr[gi], req_port[2*gi +: 2],
                        req_addr[ADDR_W*gi +: ADDR_W], req_data[DATA_W*gi +: DATA_W]};
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_ptr     = r_ptr;
    w_id      = r_id;
    w_xfer    = r_xfer;
    w_en      = r_en;
    w_dv      = 1'b0;
    w_did     = r_did;
    w_derr    = r_derr;
    req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready = w_gnt;
          w_xfer    = w_req[w_gidx];
          w_en      = 1'b1;
          w_id      = w_gidx;
          w_ptr     = (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
          w_cnt     = '0;
          w_state   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // ready beats timeout when both land on the last allowed cycle
        if (m_ready || (r_cnt == CNT_W'(TIMEOUT_CYCLES-1))) begin
          w_en    = 1'b0;
          w_dv    = 1'b1;
          w_derr  = ~m_ready;
          w_did   = r_id;
          w_cnt   = '0;
          w_state = ST_RECOVER;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_RECOVER: begin
        if (r_cnt == CNT_W'(RECOVER_CYCLES-1)) begin
          w_cnt   = '0;
          w_state = ST_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt   = '0;
        w_state = ST_RECOVER;
      end
    endcase
  end

  // Reset lands in RECOVER so a slave stuck mid-transfer can drain first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RECOVER;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_xfer  <= '0;
      r_en    <= 1'b0;
      r_dv    <= 1'b0;
      r_did   <= '0;
      r_derr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ptr   <= w_ptr;
      r_id    <= w_id;
      r_xfer  <= w_xfer;
      r_en    <= w_en;
      r_dv    <= w_dv;
      r_did   <= w_did;
      r_derr  <= w_derr;
    end
  end

  assign m_en       = r_en;
  assign m_wr       = r_xfer.wr;
  assign m_sel_port = r_xfer.port;
  assign m_addr     = r_xfer.addr;
  assign m_data     = r_xfer.data;
  assign done_valid = r_dv;
  assign done_id    = r_did;
  assign done_err   = r_derr;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized and directed bench for apb_master_arbiter against a transaction-level model.
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;
  localparam int REC = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_wr = '0;
  logic [2*N-1:0]    req_port = '0;
  logic [8*N-1:0]    req_addr = '0;
  logic [32*N-1:0]   req_data = '0;
  logic              m_en, m_wr, m_ready;
  logic [1:0]        m_sel_port;
  logic [7:0]        m_addr;
  logic [31:0]       m_data;
  logic              done_valid, done_err, busy;
  logic [IDW-1:0]    done_id;

  apb_master_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(TO), .RECOVER_CYCLES(REC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_port(req_port), .req_addr(req_addr), .req_data(req_data), .m_en(m_en), .m_wr(m_wr),
    .m_sel_port(m_sel_port), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  logic rst_q = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // slave: ready after rdy_delay cycles of en (-1 = never), stores writes per port
  int rdy_delay = 2;
  int en_cnt = 0;
  logic [31:0] slv_mem [4];
  assign m_ready = m_en && (rdy_delay >= 0) && (en_cnt >= rdy_delay);
  always @(posedge clk) begin
    en_cnt <= m_en ? en_cnt + 1 : 0;
    if (m_en && m_ready && m_wr) slv_mem[m_sel_port] <= m_data;
  end

  // reference model: pending set + rr pointer + transfer timing rules
  int   exp_ptr = 0, earliest = 0, exp_done = -1, en_len = 0, g_id = 0;
  bit   inflight = 0, rdy_seen = 0, last_err = 0;
  int   last_id = 0;
  logic e_wr; logic [1:0] e_port; logic [7:0] e_addr; logic [31:0] e_data;
  // DUT observations
  logic [N-1:0] acc = '0;
  int dut_gnt_cyc = 0, dut_gnt_n = 0, dut_gnt_id = 0, dut_done_cyc = 0, dut_done_n = 0;
  int run = 0, last_run = 0;
  int dlog_id[$], dlog_cyc[$];

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    acc = req_ready;
    if (m_en) run++;
    else if (run > 0) begin last_run = run; run = 0; end
    if (|req_ready) begin
      dut_gnt_cyc = cyc; dut_gnt_n++;
      for (int i = 0; i < N; i++) if (req_ready[i]) dut_gnt_id = i;
      dlog_id.push_back(dut_gnt_id); dlog_cyc.push_back(cyc);
    end
    if (done_valid) begin dut_done_cyc = cyc; dut_done_n++; end
    if (rst_q) begin
      chk("rst_en", m_en, 0);
      chk("rst_fields", {m_wr, m_sel_port, m_addr, m_data}, 0);
      chk("rst_done", {done_valid, done_id, done_err}, 0);
      chk("rst_busy", busy, 1);
      chk("rst_ready", req_ready, 0);
      inflight = 0; exp_ptr = 0; exp_done = -1; earliest = cyc + REC;
      last_id = 0; last_err = 0;
    end else begin
      chk("busy", busy, inflight || (cyc < earliest));
      chk("done_valid", done_valid, inflight && (cyc == exp_done));
      if (inflight && cyc == exp_done) begin
        chk("done_id", done_id, g_id);
        chk("done_err", done_err, !rdy_seen);
        last_id = g_id; last_err = !rdy_seen;
        inflight = 0; earliest = cyc + REC;
      end else begin
        chk("done_id_hold", done_id, last_id);
        chk("done_err_hold", done_err, last_err);
      end
      chk("m_en", m_en, inflight);
      if (inflight) begin
        chk("m_fields", {m_wr, m_sel_port, m_addr, m_data}, {e_wr, e_port, e_addr, e_data});
        en_len++;
        if (m_ready) rdy_seen = 1;
        if (m_ready || en_len == TO) exp_done = cyc + 1;
      end
      w = pick(req_valid, exp_ptr);
      if (!inflight && cyc >= earliest && w >= 0) begin
        chk("grant", req_ready, 1 << w);
        g_id = w; e_wr = req_wr[w]; e_port = req_port[2*w +: 2];
        e_addr = req_addr[8*w +: 8]; e_data = req_data[32*w +: 32];
        exp_ptr = (w + 1) % N; inflight = 1; en_len = 0; rdy_seen = 0; exp_done = -1;
      end else begin
        chk("no_grant", req_ready, 0);
      end
    end
  end

  bit refill = 0, rnd_mode = 0;

  task automatic set_req(input int i, input logic wr, input logic [1:0] port,
                         input logic [7:0] addr, input logic [31:0] data);
    req_valid[i] = 1'b1; req_wr[i] = wr; req_port[2*i +: 2] = port;
    req_addr[8*i +: 8] = addr; req_data[32*i +: 32] = data;
  endtask

  task automatic set_rnd(input int i);
    set_req(i, 1'($urandom), 2'($urandom), 8'($urandom), $urandom);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (acc[i]) begin
      req_valid[i] = 1'b0;
      if (refill) set_rnd(i);
    end
    if (rnd_mode) begin
      if (|acc) rdy_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO + 1));
      for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(0, 7) == 0) set_rnd(i);
    end
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = dut_done_n; n = 0;
    while (dut_done_n == d0 && n < budget) begin tick(); n++; end
    chk("wait_done", dut_done_n != d0, 1);
  endtask

  task automatic wait_grant(input int budget);
    int g0, n;
    g0 = dut_gnt_n; n = 0;
    while (dut_gnt_n == g0 && n < budget) begin tick(); n++; end
    chk("wait_grant", dut_gnt_n != g0, 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((|req_valid || busy) && n < budget) begin tick(); n++; end
    chk("drain", |req_valid || busy, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, g0, rc, dn;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // single write transfer
    rdy_delay = 2;
    set_req(1, 1'b1, PORT3, 8'h3C, 32'hDEADBEEF);
    wait_done(40);
    chk("t1_gnt_id", dut_gnt_id, 1);
    chk("t1_en_len", last_run, 3);
    chk("t1_done_lat", dut_done_cyc - dut_gnt_cyc, 4);
    chk("t1_done_id", done_id, 1);
    chk("t1_done_err", done_err, 0);
    chk("t1_slave_data", slv_mem[2], 32'hDEADBEEF);
    drain(20);

    // fairness from reset, all requesters always pending
    apply_reset();
    dlog_id.delete(); dlog_cyc.delete();
    refill = 1;
    for (int i = 0; i < N; i++) set_rnd(i);
    d = 0;
    while (dlog_id.size() < 8 && d < 200) begin tick(); d++; end
    chk("fair_count", dlog_id.size() >= 8, 1);
    for (int k = 0; k < 8; k++)
      if (k < dlog_id.size()) chk($sformatf("fair_id%0d", k), dlog_id[k], k % 4);
    for (int k = 1; k < 8; k++)
      if (k < dlog_cyc.size()) chk($sformatf("fair_gap%0d", k), dlog_cyc[k] - dlog_cyc[k-1], 5);
    refill = 0;
    drain(200);

    // timeout with a request queued behind it
    rdy_delay = -1;
    set_req(2, 1'b0, PORT1, 8'h11, 32'h0);
    wait_grant(20);
    tick();
    set_req(1, 1'b1, PORT2, 8'h22, 32'h1234_5678);
    wait_done(60);
    chk("to_en_len", last_run, TO);
    chk("to_err", done_err, 1);
    chk("to_id", done_id, 2);
    d = dut_done_cyc;
    rdy_delay = 2;
    wait_grant(20);
    chk("to_recover_gap", (dut_gnt_cyc - d) >= REC, 1);
    chk("to_next_id", dut_gnt_id, 1);
    wait_done(40);
    chk("to_next_err", done_err, 0);

    // ready on the final timeout cycle
    rdy_delay = TO - 1;
    set_req(0, 1'b1, PORT4, 8'h33, 32'hCAFE_F00D);
    wait_done(60);
    chk("col_en_len", last_run, TO);
    chk("col_err", done_err, 0);
    chk("col_data", slv_mem[3], 32'hCAFE_F00D);
    drain(20);

    // reset on the cycle after a grant
    rdy_delay = 2;
    set_req(1, 1'b1, PORT1, 8'h44, 32'h5555_AAAA);
    wait_grant(20);
    rc = cyc; dn = dut_done_n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_en", m_en, 0);
    chk("rm_busy", busy, 1);
    set_req(2, 1'b0, PORT2, 8'h55, 32'h0);
    wait_grant(20);
    chk("rm_gnt_gap", dut_gnt_cyc >= rc + REC + 1, 1);
    chk("rm_gnt_id", dut_gnt_id, 2);
    chk("rm_no_done", dut_done_n, dn);
    wait_done(40);
    chk("rm_done_id", done_id, 2);

    // request arriving mid-transfer waits for recovery
    set_req(0, 1'b1, PORT2, 8'h66, 32'h0BAD_BEEF);
    wait_grant(20);
    g0 = dut_gnt_cyc;
    tick();
    set_req(3, 1'b1, PORT3, 8'h77, 32'h7777_7777);
    wait_grant(20);
    chk("late_id", dut_gnt_id, 3);
    chk("late_gap", dut_gnt_cyc - g0, 5);
    wait_done(40);
    set_req(1, 1'b0, PORT1, 8'h88, 32'h0);
    set_req(3, 1'b0, PORT4, 8'h99, 32'h0);
    wait_grant(20);
    chk("late_ptr_wrap", dut_gnt_id, 1);
    drain(100);

    // random traffic against the model
    d = dut_gnt_n;
    rnd_mode = 1;
    repeat (2500) tick();
    rnd_mode = 0;
    drain(600);
    chk("rnd_activity", (dut_gnt_n - d) > 50, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Round-robin arbiter and APB-style transfer sequencer that shares the single 4-port APB slave bridge among NUM_REQ requesters.
- Accepts one transfer at a time (wr flag, target port, address, data) from the winning requester.
- Drives the slave's en/wr_in/sel_port/addr_in/data_in handshake and waits for ready.
- Returns a per-transfer completion pulse with requester ID and a timeout error flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID (must be at least clog2(NUM_REQ)).
- TIMEOUT_CYCLES, 16, maximum cycles en may stay high without ready before abort.
- RECOVER_CYCLES, 1, minimum cycles en is held low between transfers (must be at least 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational from registered state.
- req_wr  in  NUM_REQ  per-requester write flag.
- req_port  in  2*NUM_REQ  per-requester target port, packed, requester i at [2i+1:2i].
- req_addr  in  8*NUM_REQ  per-requester address, packed.
- req_data  in  32*NUM_REQ  per-requester write data, packed.
- m_en  out  1  to slave en.
- m_wr  out  1  to slave wr_in.
- m_sel_port  out  2  to slave sel_port.
- m_addr  out  8  to slave addr_in.
- m_data  out  32  to slave data_in.
- m_ready  in  1  from slave ready.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  ID_W  requester ID of the completed transfer.
- done_err  out  1  qualifies done_valid; 1 means timeout abort.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, ACTIVE, RECOVER.
- Reset values: m_en=0, m_wr=0, m_sel_port=0, m_addr=0, m_data=0, done_valid=0, done_id=0, done_err=0, rr pointer=0.
- After reset the FSM enters RECOVER, not IDLE, so a slave left in WAIT drains before the first transfer.
- Reset mid-transfer: m_en drops at the reset edge. No done pulse is issued for the killed transfer.
- IDLE arbitration: if any req_valid, the winner is the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
- IDLE accept: req_ready[winner]=1 in that cycle. Register the winner's wr/port/addr/data onto the m_* outputs and set m_en=1. rr pointer <= winner+1, wrapping. Go to ACTIVE.
- Arbitration is only evaluated in IDLE. Requests arriving in ACTIVE or RECOVER wait.
- Requester handshake: req_valid and its fields must stay stable until req_ready. Requesters must not withdraw a request before it is accepted.
- m_wr, m_sel_port, m_addr, m_data are held stable for the whole ACTIVE period.
- ACTIVE: a timeout counter increments each cycle.
  - m_ready=1 sampled: m_en<=0, done_valid<=1, done_err<=0, done_id<=winner. Go to RECOVER.
  - Counter reaches TIMEOUT_CYCLES-1 with m_ready=0: m_en<=0, done_valid<=1, done_err<=1. Go to RECOVER.
  - m_ready and timeout on the same cycle: ready wins, done_err=0.
- RECOVER: m_en stays 0 for RECOVER_CYCLES cycles, then go to IDLE.
- m_ready sampled outside ACTIVE is ignored.
- Timing against the slave, with G the grant edge:
  - m_en high from G+1.
  - Slave SETUP at G+1, ready high during G+2..G+3.
  - Master samples ready at G+3; done_valid high in the following cycle.
  - Next possible grant at G+5, so peak throughput is one transfer per 5 cycles with RECOVER_CYCLES=1.
- done_valid is a single-cycle pulse. done_id and done_err hold their values until the next done pulse.
- Read transfers (wr=0) are sequenced identically. No read data path exists, because the slave returns none.

Decomposition:
- Shared package apb_pkg holds:
  - State encoding localparams: ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_RECOVER=2'd2.
  - Port select constants PORT1..PORT4 = 2'd0..2'd3.
  - Widths ADDR_W=8 and DATA_W=32.
- One sub-module, rr_arbiter: a combinational round-robin priority picker. Inputs are the request vector and rr pointer; outputs are grant one-hot, grant index and any_req.
- The FSM, timeout counter and output registers live in the top.

Test Plan:
- Single request: req 1 sends wr=1, port=2, addr=8'h3C, data=32'hDEADBEEF; slave model gives ready at G+2. Expect:
  - req_ready[1] pulses at G.
  - m_en high G+1..G+3 with fields stable.
  - done_valid at G+4 with done_id=1, done_err=0.
  - Slave data_out3=32'hDEADBEEF.
- Fairness: all 4 req_valid held high for 8 transfers from reset. Expect grant order 0,1,2,3,0,1,2,3, with consecutive grant edges 5 cycles apart.
- Timeout: slave model never raises ready. Expect:
  - m_en high for exactly 16 cycles.
  - done_valid with done_err=1.
  - m_en low for at least 1 cycle before the next grant.
- Ready/timeout collision: ready first sampled on counter value 15. Expect done_err=0.
- Reset mid-transfer: rst=1 on the cycle after grant. Expect:
  - m_en=0 and all outputs at reset values at the next edge.
  - No done pulse.
  - First post-reset grant no earlier than reset release + RECOVER_CYCLES + 1.
- Late request: req 3 raised while state is ACTIVE for req 0. Expect req_ready[3] only after RECOVER completes; rr pointer ends at 0 after req 3 is granted.
